// File: rtl/tap_read_mux_rr_if.sv
//------------------------------------------------------------------------------
// tap_read_mux_rr_if : arbiter-side read bus and peripheral-side channel bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tap_read_mux_rr_if #(
  parameter int NUM_CH     = 5,
  parameter int DATA_WIDTH = 41,
  parameter int ADDR_WIDTH = 5
);
  logic                         READ_REQ_I;
  logic [ADDR_WIDTH-1:0]        READ_ADDRESS_I;
  logic                         READ_REQ_READY_O;
  logic [DATA_WIDTH-1:0]        READ_DATA_O;
  logic                         READ_VALID_O;
  logic                         READ_READY_I;
  logic                         READ_ERR_O;
  logic [ADDR_WIDTH-1:0]        VALID_ADDRESS_O;
  logic [NUM_CH-1:0]            CH_READY_O;
  logic [NUM_CH-1:0]            CH_VALID_I;
  logic [NUM_CH*DATA_WIDTH-1:0] CH_DATA_I;

  modport slave (
    input  READ_REQ_I, READ_ADDRESS_I, READ_READY_I, CH_VALID_I, CH_DATA_I,
    output READ_REQ_READY_O, READ_DATA_O, READ_VALID_O, READ_ERR_O,
           VALID_ADDRESS_O, CH_READY_O
  );

  modport master (
    output READ_REQ_I, READ_ADDRESS_I, READ_READY_I, CH_VALID_I, CH_DATA_I,
    input  READ_REQ_READY_O, READ_DATA_O, READ_VALID_O, READ_ERR_O,
           VALID_ADDRESS_O, CH_READY_O
  );
endinterface

`default_nettype wire

// File: rtl/tap_read_mux_rr.sv
//------------------------------------------------------------------------------
// tap_read_mux_rr : TAP read mux with per-request timeout and round-robin hint
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tap_read_mux_rr #(
  parameter int                           NUM_CH     = 5,
  parameter int                           DATA_WIDTH = 41,
  parameter int                           ADDR_WIDTH = 5,
  parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0]        NOP_ADDR   = ADDR_WIDTH'(5'h1F),
  parameter int                           TIMEOUT    = 256
) (
  input  wire logic          CLK_I,
  input  wire logic          RST_I,
  tap_read_mux_rr_if.slave   bus
);

  localparam int c_SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT  = '1;
  localparam logic [c_SEL_W-1:0] c_PTR_INIT = c_SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_SEL_W-1:0]      r_sel;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_err;
  logic [ADDR_WIDTH-1:0]   r_vaddr;
  logic [c_SEL_W-1:0]      r_rr_ptr;

  logic                    w_hit;
  logic [c_SEL_W-1:0]      w_hit_sel;
  logic                    w_sel_valid;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [NUM_CH-1:0]       w_ch_ready;
  logic                    w_rr_found;
  logic [c_SEL_W-1:0]      w_rr_sel;
  logic [ADDR_WIDTH-1:0]   w_rr_addr;

  // Descending scan so the lowest-index channel wins on shared addresses.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (CH_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.READ_ADDRESS_I) begin
        w_hit     = 1'b1;
        w_hit_sel = c_SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == c_SEL_W'(i)) begin
        w_sel_valid = bus.CH_VALID_I[i];
        w_sel_data  = bus.CH_DATA_I[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_ch_ready = '0;
    if (!RST_I && r_state == S_WAIT) begin
      for (int i = 0; i < NUM_CH; i++) begin
        w_ch_ready[i] = (r_sel == c_SEL_W'(i)) && bus.CH_VALID_I[i];
      end
    end
  end

  // Offsets scanned from farthest to nearest so the nearest valid channel after the pointer wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = r_rr_ptr;
    w_rr_addr  = NOP_ADDR;
    for (int off = NUM_CH; off >= 1; off--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((int'(r_rr_ptr) + off == i || int'(r_rr_ptr) + off == i + NUM_CH) &&
            bus.CH_VALID_I[i]) begin
          w_rr_found = 1'b1;
          w_rr_sel   = c_SEL_W'(i);
          w_rr_addr  = CH_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_vaddr  <= NOP_ADDR;
      r_rr_ptr <= c_PTR_INIT;
    end else begin
      if (w_rr_found) begin
        r_vaddr  <= w_rr_addr;
        r_rr_ptr <= w_rr_sel;
      end else begin
        r_vaddr  <= NOP_ADDR;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.READ_REQ_I) begin
            r_sel <= w_hit_sel;
            r_cnt <= '0;
            if (w_hit) begin
              r_state <= S_WAIT;
            end else begin
              r_data  <= '0;
              r_err   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (w_sel_valid) begin
            r_data  <= w_sel_data;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else if (r_cnt != c_CNT_SAT) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.READ_READY_I) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.READ_REQ_READY_O = (r_state == S_IDLE);
  assign bus.READ_DATA_O      = r_data;
  assign bus.READ_VALID_O     = r_valid;
  assign bus.READ_ERR_O       = r_err;
  assign bus.VALID_ADDRESS_O  = r_vaddr;
  assign bus.CH_READY_O       = w_ch_ready;

endmodule

`default_nettype wire

// File: tb/tb_tap_read_mux_rr.sv
//------------------------------------------------------------------------------
// tb_tap_read_mux_rr : directed + randomized bench with a transaction-level model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tap_read_mux_rr;

  localparam int NUM_CH  = 5;
  localparam int DW      = 41;
  localparam int AW      = 5;
  localparam int TIMEOUT = 8;
  localparam logic [NUM_CH*AW-1:0] CH_ADDR = {5'h11, 5'h0A, 5'h0A, 5'h07, 5'h03};
  localparam logic [AW-1:0] NOP = 5'h1F;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;

  tap_read_mux_rr_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  tap_read_mux_rr #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .CH_ADDR(CH_ADDR), .NOP_ADDR(NOP), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus  (bus)
  );

  always #5 CLK_I = ~CLK_I;

  logic [DW-1:0] ch_data [NUM_CH];
  logic [AW-1:0] addr_map [NUM_CH] = '{5'h03, 5'h07, 5'h0A, 5'h0A, 5'h11};

  always_comb begin
    bus.CH_DATA_I = '0;
    for (int i = 0; i < NUM_CH; i++) bus.CH_DATA_I[i*DW +: DW] = ch_data[i];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one request in flight, then a held response.
  bit            m_started = 0;
  bit            m_waiting = 0;
  bit            m_holding = 0;
  int            m_ch      = 0;
  int            m_waited  = 0;
  int            m_rr_last = NUM_CH - 1;
  int            m_k;
  int            m_c;
  logic [DW-1:0] m_data    = '0;
  bit            m_err     = 0;
  logic [AW-1:0] m_vaddr   = NOP;

  initial forever begin
    @(posedge CLK_I);
    if (RST_I) begin
      m_started = 1;
      m_waiting = 0;
      m_holding = 0;
      m_data    = '0;
      m_err     = 0;
      m_vaddr   = NOP;
      m_rr_last = NUM_CH - 1;
    end else begin
      m_k = -1;
      for (int j = 1; j <= NUM_CH; j++) begin
        m_c = (m_rr_last + j) % NUM_CH;
        if (m_k < 0 && bus.CH_VALID_I[m_c]) m_k = m_c;
      end
      if (m_k >= 0) begin
        m_vaddr   = addr_map[m_k];
        m_rr_last = m_k;
      end else begin
        m_vaddr = NOP;
      end

      if (m_holding) begin
        if (bus.READ_READY_I) m_holding = 0;
      end else if (m_waiting) begin
        if (bus.CH_VALID_I[m_ch]) begin
          m_waiting = 0; m_holding = 1; m_data = ch_data[m_ch]; m_err = 0;
        end else begin
          m_waited++;
          if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
            m_waiting = 0; m_holding = 1; m_data = '0; m_err = 1;
          end
        end
      end else if (bus.READ_REQ_I) begin
        m_ch = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (addr_map[i] == bus.READ_ADDRESS_I) m_ch = i;
        if (m_ch < 0) begin
          m_holding = 1; m_data = '0; m_err = 0;
        end else begin
          m_waiting = 1; m_waited = 0;
        end
      end
    end
  end

  logic [NUM_CH-1:0] exp_ch_ready;

  initial forever begin
    @(negedge CLK_I);
    #3;
    if (m_started) begin
      exp_ch_ready = '0;
      if (!RST_I && m_waiting && bus.CH_VALID_I[m_ch]) exp_ch_ready[m_ch] = 1'b1;
      check("m_req_ready", 64'(bus.READ_REQ_READY_O), 64'(!(m_waiting || m_holding)));
      check("m_valid",     64'(bus.READ_VALID_O),     64'(m_holding));
      check("m_ch_ready",  64'(bus.CH_READY_O),       64'(exp_ch_ready));
      check("m_vaddr",     64'(bus.VALID_ADDRESS_O),  64'(m_vaddr));
      if (m_holding) begin
        check("m_data", 64'(bus.READ_DATA_O), 64'(m_data));
        check("m_err",  64'(bus.READ_ERR_O),  64'(m_err));
      end
    end
  end

  logic [63:0] rnd;
  int          vprob;

  initial begin
    bus.READ_REQ_I     = 1'b0;
    bus.READ_ADDRESS_I = '0;
    bus.READ_READY_I   = 1'b0;
    bus.CH_VALID_I     = '0;
    for (int i = 0; i < NUM_CH; i++) ch_data[i] = '0;
    ch_data[0] = 41'h0_ABCD_EF01;
    RST_I = 1'b1;

    repeat (2) @(negedge CLK_I);
    #2 check("rst_ch_ready", 64'(bus.CH_READY_O), 64'h0);
    @(negedge CLK_I); RST_I = 1'b0;
    @(negedge CLK_I); #2;
    check("idle_vaddr",     64'(bus.VALID_ADDRESS_O),  64'h1F);
    check("idle_valid",     64'(bus.READ_VALID_O),     64'h0);
    check("idle_req_ready", 64'(bus.READ_REQ_READY_O), 64'h1);
    check("idle_ch_ready",  64'(bus.CH_READY_O),       64'h0);
    check("idle_data",      64'(bus.READ_DATA_O),      64'h0);

    // Channel 2 read, arbiter stalls three cycles before consuming.
    @(negedge CLK_I);
    ch_data[2] = 41'h1_2345_6789; bus.CH_VALID_I = 5'b00100;
    bus.READ_REQ_I = 1'b1; bus.READ_ADDRESS_I = 5'h0A;
    @(negedge CLK_I); bus.READ_REQ_I = 1'b0;
    #2 check("ch2_ready_pulse", 64'(bus.CH_READY_O), 64'h04);
    check("ch2_valid_early", 64'(bus.READ_VALID_O), 64'h0);
    @(negedge CLK_I); #2;
    check("ch2_valid",    64'(bus.READ_VALID_O), 64'h1);
    check("ch2_data",     64'(bus.READ_DATA_O),  64'h1_2345_6789);
    check("ch2_err",      64'(bus.READ_ERR_O),   64'h0);
    check("ch2_ready_lo", 64'(bus.CH_READY_O),   64'h0);
    @(negedge CLK_I); #2 check("ch2_data_hold1", 64'(bus.READ_DATA_O), 64'h1_2345_6789);
    @(negedge CLK_I); #2 check("ch2_data_hold2", 64'(bus.READ_DATA_O), 64'h1_2345_6789);
    check("ch2_valid_hold", 64'(bus.READ_VALID_O), 64'h1);
    bus.READ_READY_I = 1'b1;
    @(negedge CLK_I); bus.READ_READY_I = 1'b0;
    #2 check("ch2_done_valid", 64'(bus.READ_VALID_O),     64'h0);
    check("ch2_done_idle",     64'(bus.READ_REQ_READY_O), 64'h1);

    // Unmapped address completes immediately without touching a channel.
    @(negedge CLK_I);
    bus.CH_VALID_I = '0; bus.READ_REQ_I = 1'b1; bus.READ_ADDRESS_I = 5'h05;
    @(negedge CLK_I); bus.READ_REQ_I = 1'b0;
    #2 check("unm_valid", 64'(bus.READ_VALID_O), 64'h1);
    check("unm_data",     64'(bus.READ_DATA_O),  64'h0);
    check("unm_err",      64'(bus.READ_ERR_O),   64'h0);
    check("unm_ch_ready", 64'(bus.CH_READY_O),   64'h0);
    bus.READ_READY_I = 1'b1;
    @(negedge CLK_I); bus.READ_READY_I = 1'b0;

    // Timeout on channel 1 which never becomes valid.
    @(negedge CLK_I); bus.READ_REQ_I = 1'b1; bus.READ_ADDRESS_I = 5'h07;
    @(negedge CLK_I); bus.READ_REQ_I = 1'b0;
    repeat (7) @(negedge CLK_I);
    #2 check("to_not_yet", 64'(bus.READ_VALID_O), 64'h0);
    @(negedge CLK_I); #2;
    check("to_valid", 64'(bus.READ_VALID_O), 64'h1);
    check("to_err",   64'(bus.READ_ERR_O),   64'h1);
    check("to_data",  64'(bus.READ_DATA_O),  64'h0);
    bus.CH_VALID_I = 5'b00010;
    #1 check("to_late_ready", 64'(bus.CH_READY_O), 64'h0);
    @(negedge CLK_I); #2 check("to_late_ready2", 64'(bus.CH_READY_O), 64'h0);
    bus.READ_READY_I = 1'b1;
    @(negedge CLK_I); bus.READ_READY_I = 1'b0; bus.CH_VALID_I = '0;

    // Round-robin rotation from a fresh reset.
    @(negedge CLK_I); RST_I = 1'b1; bus.CH_VALID_I = 5'b10101;
    @(negedge CLK_I); RST_I = 1'b0;
    #2 check("rr_reset", 64'(bus.VALID_ADDRESS_O), 64'h1F);
    @(negedge CLK_I); #2 check("rr_0",  64'(bus.VALID_ADDRESS_O), 64'h03);
    @(negedge CLK_I); #2 check("rr_2",  64'(bus.VALID_ADDRESS_O), 64'h0A);
    @(negedge CLK_I); #2 check("rr_4",  64'(bus.VALID_ADDRESS_O), 64'h11);
    @(negedge CLK_I); #2 check("rr_0b", 64'(bus.VALID_ADDRESS_O), 64'h03);

    // Reset while holding a response, then a normal read.
    @(negedge CLK_I); bus.READ_REQ_I = 1'b1; bus.READ_ADDRESS_I = 5'h03;
    @(negedge CLK_I); bus.READ_REQ_I = 1'b0;
    @(negedge CLK_I); #2;
    check("hr_valid", 64'(bus.READ_VALID_O), 64'h1);
    check("hr_data",  64'(bus.READ_DATA_O),  64'h0_ABCD_EF01);
    RST_I = 1'b1;
    @(negedge CLK_I); #2;
    check("hr_rst_valid", 64'(bus.READ_VALID_O),     64'h0);
    check("hr_rst_idle",  64'(bus.READ_REQ_READY_O), 64'h1);
    check("hr_rst_chrdy", 64'(bus.CH_READY_O),       64'h0);
    RST_I = 1'b0;
    @(negedge CLK_I);
    ch_data[4] = 41'h1_5555_AAAA; bus.READ_REQ_I = 1'b1; bus.READ_ADDRESS_I = 5'h11;
    @(negedge CLK_I); bus.READ_REQ_I = 1'b0;
    @(negedge CLK_I); #2;
    check("hr_new_valid", 64'(bus.READ_VALID_O), 64'h1);
    check("hr_new_data",  64'(bus.READ_DATA_O),  64'h1_5555_AAAA);
    bus.READ_READY_I = 1'b1;
    @(negedge CLK_I); bus.READ_READY_I = 1'b0;

    // Randomized traffic; valid density changes every 50 cycles to exercise timeouts.
    vprob = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK_I);
      if (cyc % 50 == 0) vprob = (($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 10 : 50));
      RST_I = ($urandom_range(0, 299) == 0);
      bus.READ_REQ_I = ($urandom_range(0, 2) != 0);
      m_c = int'($urandom_range(0, 6));
      rnd = {$urandom(), $urandom()};
      bus.READ_ADDRESS_I = (m_c < NUM_CH) ? addr_map[m_c] : rnd[AW-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        bus.CH_VALID_I[i] = ($urandom_range(0, 99) < vprob);
        rnd = {$urandom(), $urandom()};
        ch_data[i] = rnd[DW-1:0];
      end
      bus.READ_READY_I = ($urandom_range(0, 1) == 1);
    end

    @(negedge CLK_I);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tap_read_mux_rr.md
Name: tap_read_mux_rr

Overview:
- Parametrised read multiplexer between the UART TAP read arbiter and NUM_CH read-only peripherals (DMI, status/data buffers, and similar).
- Accepts one address-tagged read request at a time and performs a valid/ready transfer with the addressed channel.
- Returns the data through a registered output with a full valid/ready handshake and a per-request timeout.
- Publishes a round-robin "next ready channel" address so the arbiter can schedule reads fairly.

Parameters:
- NUM_CH, 5, number of peripheral channels (1..16).
- DATA_WIDTH, 41, read data width; narrower channels are zero-extended by the integrator.
- ADDR_WIDTH, 5, TAP address width (IRLENGTH).
- CH_ADDR, {5{5'h00}}, flattened NUM_CH*ADDR_WIDTH address map; channel i owns slice i.
- NOP_ADDR, 5'h1F, address reported when no channel is valid.
- TIMEOUT, 256, cycles to wait for a channel's valid; 0 disables the timeout.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous active-high reset.
- READ_REQ_I  in  1  read request from arbiter.
- READ_ADDRESS_I  in  ADDR_WIDTH  target address, sampled with the request.
- READ_REQ_READY_O  out  1  high in IDLE only; a request is accepted when READ_REQ_I and this are both high.
- READ_DATA_O  out  DATA_WIDTH  registered read data.
- READ_VALID_O  out  1  read data valid.
- READ_READY_I  in  1  arbiter consumes the data.
- READ_ERR_O  out  1  qualifies READ_VALID_O; high means the request timed out.
- VALID_ADDRESS_O  out  ADDR_WIDTH  registered round-robin pick among valid channels.
- CH_READY_O  out  NUM_CH  per-channel ready; one-hot or zero.
- CH_VALID_I  in  NUM_CH  per-channel valid.
- CH_DATA_I  in  NUM_CH*DATA_WIDTH  flattened channel data; channel i owns slice i.

Behaviour:
- Reset (any cycle, including mid-transfer):
  - state=IDLE; READ_VALID_O=0, READ_ERR_O=0, READ_DATA_O=0.
  - VALID_ADDRESS_O=NOP_ADDR; RR pointer=NUM_CH-1, so channel 0 is preferred first.
  - Timeout counter=0.
  - CH_READY_O=0 combinationally while RST_I is high.
- Decode:
  - Address matches channel i when CH_ADDR slice i equals the sampled address.
  - If several channels share an address, the lowest index wins.
  - No match = unmapped.
- State machine:
  - IDLE: on accepted request, latch the address and decode result, clear the counter. Mapped -> WAIT. Unmapped -> HOLD with data 0 and ERR=0.
  - WAIT: CH_READY_O[sel] = CH_VALID_I[sel], combinational. When it is high, capture the channel data into READ_DATA_O, set ERR=0, go to HOLD. This gives exactly one ready/valid beat per request.
  - WAIT timeout: otherwise increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without valid, go to HOLD with data 0 and ERR=1. CH_READY_O stays 0.
  - HOLD: READ_VALID_O=1 with data and ERR stable. On READ_READY_I, go to IDLE; READ_VALID_O falls the next cycle. A new request is accepted no earlier than the cycle after the handshake.
- Latency:
  - Request accepted at edge t, channel already valid: CH_READY_O high in cycle t+1, READ_VALID_O high from t+2.
  - Unmapped address: READ_VALID_O high from t+1.
- CH_READY_O is never asserted outside WAIT and never for more than one channel.
- VALID_ADDRESS_O (updated every cycle, independent of the FSM):
  - Search CH_VALID_I from pointer+1 upward, wrapping modulo NUM_CH, for the first set bit.
  - Found channel k: VALID_ADDRESS_O <= CH_ADDR[k] and pointer <= k.
  - None found: VALID_ADDRESS_O <= NOP_ADDR, pointer unchanged.
  - The channel in WAIT/HOLD is not excluded.
- Counter width is clog2(TIMEOUT+1), saturating; no wrap-around.
- READ_ADDRESS_I changes while not in IDLE are ignored.
- NUM_CH=1: the RR search degenerates to the valid bit of channel 0.

Test Plan:
- Reset then idle, all CH_VALID_I=0 -> VALID_ADDRESS_O=NOP_ADDR, READ_VALID_O=0, CH_READY_O=0, READ_REQ_READY_O=1.
- Request channel 2 (valid, data 41'h1_2345_6789) at edge t -> CH_READY_O=5'b00100 for one cycle at t+1; READ_DATA_O=41'h1_2345_6789 with READ_VALID_O=1 from t+2. READ_READY_I held low 3 cycles -> data stable; handshake -> IDLE.
- Request to an unmapped address -> READ_VALID_O=1 at t+1, READ_DATA_O=0, READ_ERR_O=0, no CH_READY_O pulse.
- TIMEOUT=8, request a channel whose valid stays 0 -> after 8 WAIT cycles READ_VALID_O=1, READ_ERR_O=1, data 0. A late valid afterwards gets no ready.
- CH_VALID_I=5'b10101 held constant -> VALID_ADDRESS_O cycles CH_ADDR[0], [2], [4], [0], ... on successive cycles.
- RST_I asserted in HOLD with READ_VALID_O=1 -> the next edge gives READ_VALID_O=0, IDLE; a new request completes normally.
